// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the single-port data memory between the pipeline MEM
//               stage and a host loader; bounded host bursts, starvation
//               preemption, and pipeline stall while the host owns the port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int HOST_BURST_MAX = 16,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic              host_last,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int BEAT_W   = (HOST_BURST_MAX > 1) ? $clog2(HOST_BURST_MAX) : 1;

    localparam logic [STARVE_W-1:0] c_starve_max = STARVE_W'(STARVE_LIMIT);
    localparam logic [BEAT_W-1:0]   c_beat_last  = BEAT_W'(HOST_BURST_MAX - 1);

    typedef enum logic [0:0] {
        CPU_OWN  = 1'b0,
        HOST_OWN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [STARVE_W-1:0] w_starve_nxt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;

    logic w_cpu_req;
    logic w_host_beat;
    logic w_host_rd;

    assign w_cpu_req   = cpu_re | cpu_we;
    assign w_host_beat = (r_state == HOST_OWN) & host_valid;
    assign w_host_rd   = w_host_beat & ~host_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= CPU_OWN;
            r_starve_cnt <= '0;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_beat_cnt   <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_beat_nxt   = r_beat_cnt;
        unique case (r_state)
            CPU_OWN: begin
                if (host_valid) begin
                    if (w_cpu_req && (r_starve_cnt != c_starve_max)) begin
                        w_starve_nxt = r_starve_cnt + 1'b1;
                    end
                    // The CPU access in this cycle still completes; the host
                    // takes the port from the next cycle on.
                    if (!w_cpu_req || (r_starve_cnt == c_starve_max)) begin
                        w_state_nxt  = HOST_OWN;
                        w_starve_nxt = '0;
                    end
                end else begin
                    w_starve_nxt = '0;
                end
            end
            HOST_OWN: begin
                w_starve_nxt = '0;
                if (!host_valid) begin
                    w_state_nxt = CPU_OWN;
                    w_beat_nxt  = '0;
                end else if (host_last || (r_beat_cnt == c_beat_last)) begin
                    w_state_nxt = CPU_OWN;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt  = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = CPU_OWN;
            end
        endcase
    end

    // Strobes are gated by reset so nothing reaches memory while it is held.
    always_comb begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        host_ready = 1'b0;
        cpu_stall  = 1'b0;
        if (r_state == HOST_OWN) begin
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
            mem_we     = reset & host_valid & host_we;
            mem_re     = reset & host_valid & ~host_we;
            host_ready = 1'b1;
            cpu_stall  = w_cpu_req;
        end else begin
            mem_we     = reset & cpu_we;
            mem_re     = reset & cpu_re;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_host_rd;
            if (w_host_rd) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rdata;
    assign cpu_rdata   = mem_rdata;

endmodule

`default_nettype wire
